integrate_dump: RTL and testbench

INTEGRATE_DUMP -- requirements
Module: integrate_dump

---
 rtl/integrate_dump.sv | 96 +++++++++
 tb/tb_integrate_dump.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/integrate_dump.sv
// integrate_dump: integrate-and-dump decimator.
// Sums DECIM sign-extended samples into a 32-bit wrapping accumulator and
// presents each block sum on a valid/ready output with backpressure.
// Optional feature macro: INTDUMP_OVF_FLAG_EN adds the sticky ovf_out flag.
module integrate_dump #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned DECIM    = 8
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                clear_in,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid_in,
  output logic                sample_ready_out,
  output logic [31:0]         sum_out,
  output logic                sum_valid_out,
  input  logic                sum_ready_in
`ifdef INTDUMP_OVF_FLAG_EN
  ,
  output logic                ovf_out
`endif
);

  localparam int unsigned ACC_W = 32;
  localparam int unsigned CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic [ACC_W-1:0] sample_ext;
  logic [ACC_W-1:0] sum_nxt;
  logic             accept;
  logic             last;

  // Accept only when not flushing and the output slot is free or being drained.
  assign sample_ready_out = !clear_in && (!sum_valid_out || sum_ready_in);

  // Sign extension, wrapping add, and block-completion detect.
  always_comb begin
    sample_ext = {{(ACC_W-SAMPLE_W){sample_in[SAMPLE_W-1]}}, sample_in};
    sum_nxt    = acc + sample_ext;
    accept     = sample_valid_in && sample_ready_out;
    last       = (count == CNT_W'(DECIM - 1));
  end

  // Accumulator and sample counter; cleared on block completion or flush.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      acc   <= '0;
      count <= '0;
    end else if (clear_in) begin
      acc   <= '0;
      count <= '0;
    end else if (accept) begin
      if (last) begin
        acc   <= '0;
        count <= '0;
      end else begin
        acc   <= sum_nxt;
        count <= count + CNT_W'(1);
      end
    end
  end

  // Output register: load on completion (even while draining), drop when consumed.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sum_out       <= '0;
      sum_valid_out <= 1'b0;
    end else if (accept && last) begin
      sum_out       <= sum_nxt;
      sum_valid_out <= 1'b1;
    end else if (sum_ready_in) begin
      sum_valid_out <= 1'b0;
    end
  end

`ifdef INTDUMP_OVF_FLAG_EN
  logic add_ovf;

  // Signed overflow: operands share a sign that the result does not.
  assign add_ovf = (acc[ACC_W-1] == sample_ext[ACC_W-1]) &&
                   (sum_nxt[ACC_W-1] != acc[ACC_W-1]);

  // Sticky overflow flag, cleared by reset or flush.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ovf_out <= 1'b0;
    end else if (clear_in) begin
      ovf_out <= 1'b0;
    end else if (accept && add_ovf) begin
      ovf_out <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_integrate_dump.sv
// Directed bench for integrate_dump (SAMPLE_W=16, DECIM=8).
module tb_integrate_dump;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [15:0] sample;
  logic        valid;
  logic        ready;
  logic [31:0] sum;
  logic        sum_valid;
  logic        sum_ready;
  int          n_pass  = 0;
  int          n_total = 0;
  int          n_acc;

`ifdef INTDUMP_OVF_FLAG_EN
  logic        ovf;
  logic        clr2;
  logic [23:0] smp2;
  logic        v2;
  logic        rdy2;
  logic [31:0] sum2;
  logic        sv2;
  logic        ovf2;
`endif

  always #5 clk = ~clk;

  integrate_dump #(.SAMPLE_W(16), .DECIM(8)) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .clear_in        (clear),
    .sample_in       (sample),
    .sample_valid_in (valid),
    .sample_ready_out(ready),
    .sum_out         (sum),
    .sum_valid_out   (sum_valid),
    .sum_ready_in    (sum_ready)
`ifdef INTDUMP_OVF_FLAG_EN
    ,
    .ovf_out         (ovf)
`endif
  );

`ifdef INTDUMP_OVF_FLAG_EN
  integrate_dump #(.SAMPLE_W(24), .DECIM(256)) dut2 (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .clear_in        (clr2),
    .sample_in       (smp2),
    .sample_valid_in (v2),
    .sample_ready_out(rdy2),
    .sum_out         (sum2),
    .sum_valid_out   (sv2),
    .sum_ready_in    (1'b1),
    .ovf_out         (ovf2)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic send(input logic [15:0] s);
    sample = s;
    valid  = 1'b1;
    @(posedge clk); #1;
    valid  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; sample = '0; valid = 1'b0; sum_ready = 1'b1;
`ifdef INTDUMP_OVF_FLAG_EN
    clr2 = 1'b0; smp2 = '0; v2 = 1'b0;
`endif
    // Reset state
    #3;
    chk("rst_sum", sum, 32'd0);
    chk("rst_valid", 32'(sum_valid), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    clear = 1'b1; #1;
    chk("rst_ready_clear", 32'(ready), 32'd0);
    clear = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Samples 1..8 -> 36, valid for exactly one cycle
    for (int i = 1; i <= 8; i++) begin
      send(16'(i));
      if (i == 7) chk("seq_valid_early", 32'(sum_valid), 32'd0);
    end
    chk("seq_sum", sum, 32'd36);
    chk("seq_valid", 32'(sum_valid), 32'd1);
    @(posedge clk); #1;
    chk("seq_valid_drop", 32'(sum_valid), 32'd0);

    // Sign extension: 8 x -32768
    for (int i = 0; i < 8; i++) send(16'h8000);
    chk("neg_sum", sum, 32'hFFFC0000);
    @(posedge clk); #1;

    // Backpressure: 16 offered, 8 accepted, result held
    sum_ready = 1'b0;
    n_acc = 0;
    sample = 16'd4; valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (ready) n_acc++;
      @(posedge clk); #1;
    end
    valid = 1'b0;
    chk("bp_accepts", 32'(n_acc), 32'd8);
    chk("bp_sum", sum, 32'd32);
    chk("bp_valid", 32'(sum_valid), 32'd1);
    chk("bp_ready", 32'(ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_sum_hold", sum, 32'd32);
    chk("bp_valid_hold", 32'(sum_valid), 32'd1);
    sum_ready = 1'b1; #1;
    chk("bp_ready_release", 32'(ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_consumed", 32'(sum_valid), 32'd0);

    // Clear after 3 x 100, then 8 x 1 with idle gap -> 8
    for (int i = 0; i < 3; i++) send(16'd100);
    clear = 1'b1; sample = 16'd100; valid = 1'b1; #1;
    chk("clr_ready", 32'(ready), 32'd0);
    @(posedge clk); #1;
    clear = 1'b0; valid = 1'b0;
    for (int i = 0; i < 3; i++) send(16'd1);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) send(16'd1);
    chk("clr_sum", sum, 32'd8);
    chk("clr_valid", 32'(sum_valid), 32'd1);

    // Clear leaves a pending result untouched
    sum_ready = 1'b0;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clr_hold_sum", sum, 32'd8);
    chk("clr_hold_valid", 32'(sum_valid), 32'd1);
    sum_ready = 1'b1;
    @(posedge clk); #1;

    // Async reset mid-block after 5 samples
    for (int i = 0; i < 5; i++) send(16'd7);
    @(posedge clk); #3;
    rst_n = 1'b0; #1;
    chk("arst_valid", 32'(sum_valid), 32'd0);
    chk("arst_sum", sum, 32'd0);
    chk("arst_acc", dut.acc, 32'd0);
    chk("arst_count", 32'(dut.count), 32'd0);
    chk("arst_ready", 32'(ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) send(16'd9);
    chk("arst_post_sum", sum, 32'd72);
    chk("arst_post_valid", 32'(sum_valid), 32'd1);
    @(posedge clk); #1;

`ifdef INTDUMP_OVF_FLAG_EN
    // Overflow flag: max block fits, forced near-max accumulator overflows
    chk("ovf_main", 32'(ovf), 32'd0);
    smp2 = 24'h7FFFFF; v2 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
    end
    v2 = 1'b0;
    chk("ovf_max_sum", sum2, 32'h7FFFFF00);
    chk("ovf_max_flag", 32'(ovf2), 32'd0);
    force dut2.acc = 32'h7FFFFFF0;
    #1;
    release dut2.acc;
    smp2 = 24'h000010; v2 = 1'b1;
    @(posedge clk); #1;
    v2 = 1'b0;
    chk("ovf_set", 32'(ovf2), 32'd1);
    @(posedge clk); #1;
    chk("ovf_sticky", 32'(ovf2), 32'd1);
    clr2 = 1'b1;
    @(posedge clk); #1;
    clr2 = 1'b0;
    chk("ovf_clear", 32'(ovf2), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
